// File: rtl/w0rm_load_store_unit.sv
// W0RM load/store unit: issues word-aligned bus transactions, performs sub-word stores as
// read-modify-write, and returns aligned/extended load data with misalign and timeout errors.
module w0rm_load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic                      op_load,
    input  logic                      op_store,
    input  logic [1:0]                op_size,
    input  logic                      op_signed,
    input  logic [ADDR_WIDTH-1:0]     op_addr,
    input  logic [DATA_WIDTH-1:0]     op_data,
    input  logic [REG_ADDR_WIDTH-1:0] op_dest,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic                      bus_read,
    output logic                      bus_write,
    output logic                      bus_valid_in,
    output logic [DATA_WIDTH-1:0]     bus_data_in,
    input  logic [DATA_WIDTH-1:0]     bus_data_out,
    input  logic                      bus_valid_out,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_dest,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      st_done,
    output logic                      err_valid,
    output logic [1:0]                err_code
);

    // Wait counter only needs to reach TIMEOUT-1; the timeout fires on that cycle.
    localparam int CW = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, WR_WAIT} state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_cnt;
    logic [1:0]                  r_off;
    logic [1:0]                  r_size;
    logic                        r_signed;
    logic [DATA_WIDTH-1:0]       r_data;
    logic [REG_ADDR_WIDTH-1:0]   r_dest;

    logic                        w_accept;
    logic                        w_misalign;
    logic                        w_timeout;
    logic [4:0]                  w_shamt;
    logic [15:0]                 w_lane;
    logic [DATA_WIDTH-1:0]       w_ld_data;
    logic [DATA_WIDTH-1:0]       w_mask;
    logic [DATA_WIDTH-1:0]       w_merged;

    assign op_ready   = (r_state == IDLE);
    assign w_accept   = op_valid && op_ready && (op_load || op_store);
    assign w_misalign = ((op_size == 2'b01) && op_addr[0]) ||
                        (op_size[1] && (op_addr[1:0] != 2'b00));
    assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));

    // Lane extraction and merge both key off the latched byte offset.
    assign w_shamt  = {r_off, 3'b000};
    assign w_lane   = 16'(bus_data_out >> w_shamt);
    assign w_mask   = (r_size[0] ? DATA_WIDTH'(16'hFFFF) : DATA_WIDTH'(8'hFF)) << w_shamt;
    assign w_merged = (bus_data_out & ~w_mask) | ((r_data << w_shamt) & w_mask);

    always_comb begin
        w_ld_data = bus_data_out;
        if (!r_size[1]) begin
            if (r_size[0])
                w_ld_data = {{(DATA_WIDTH-16){r_signed & w_lane[15]}}, w_lane[15:0]};
            else
                w_ld_data = {{(DATA_WIDTH-8){r_signed & w_lane[7]}}, w_lane[7:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_data       <= '0;
            r_dest       <= '0;
            bus_addr     <= '0;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            bus_valid_in <= 1'b0;
            bus_data_in  <= '0;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            st_done      <= 1'b0;
            err_valid    <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            bus_valid_in <= 1'b0;
            wb_valid     <= 1'b0;
            st_done      <= 1'b0;
            err_valid    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_off    <= op_addr[1:0];
                        r_size   <= op_size;
                        r_signed <= op_signed;
                        r_data   <= op_data;
                        r_dest   <= op_dest;
                        if (w_misalign) begin
                            err_valid <= 1'b1;
                            err_code  <= 2'b01;
                        end else begin
                            bus_addr     <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus_valid_in <= 1'b1;
                            r_cnt        <= '0;
                            if (op_load) begin
                                bus_read  <= 1'b1;
                                bus_write <= 1'b0;
                                r_state   <= RD_WAIT;
                            end else if (op_size[1]) begin
                                bus_read    <= 1'b0;
                                bus_write   <= 1'b1;
                                bus_data_in <= op_data;
                                r_state     <= WR_WAIT;
                            end else begin
                                bus_read  <= 1'b1;
                                bus_write <= 1'b0;
                                r_state   <= RMW_RD;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus_valid_out) begin
                        wb_valid <= 1'b1;
                        wb_data  <= w_ld_data;
                        wb_dest  <= r_dest;
                        bus_read <= 1'b0;
                        r_state  <= IDLE;
                    end else if (w_timeout) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b10;
                        bus_read  <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RMW_RD: begin
                    if (bus_valid_out) begin
                        bus_read     <= 1'b0;
                        bus_write    <= 1'b1;
                        bus_data_in  <= w_merged;
                        bus_valid_in <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= RMW_WR;
                    end else if (w_timeout) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b10;
                        bus_read  <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RMW_WR, WR_WAIT: begin
                    if (bus_valid_out) begin
                        st_done   <= 1'b1;
                        bus_write <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_timeout) begin
                        err_valid <= 1'b1;
                        err_code  <= 2'b10;
                        bus_write <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_state <= WR_WAIT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
